// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg
// Shared decode constants for the MIPS32 decode stage: primary opcodes,
// SPECIAL funct codes, ALU operation / result-class encodings, the decode
// bundle passed between decode and operand selection, and small immediate
// extension helpers.
package id_stage_pipe_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  // SPECIAL funct codes (inst[5:0])
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SYNC = 6'b001111;
  localparam logic [5:0] F_MOVZ = 6'b001010;
  localparam logic [5:0] F_MOVN = 6'b001011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  // ALU operation encodings
  typedef enum logic [7:0] {
    NOP_OP   = 8'b0000_0000,
    AND_OP   = 8'b0010_0100,
    OR_OP    = 8'b0010_0101,
    XOR_OP   = 8'b0010_0110,
    NOR_OP   = 8'b0010_0111,
    ADDU_OP  = 8'b0010_0001,
    ADDIU_OP = 8'b0101_0110,
    SLL_OP   = 8'b0111_1100,
    SRL_OP   = 8'b0000_0010,
    SRA_OP   = 8'b0000_0011,
    MOVZ_OP  = 8'b0000_1010,
    MOVN_OP  = 8'b0000_1011,
    MFHI_OP  = 8'b0001_0000,
    MTHI_OP  = 8'b0001_0001,
    MFLO_OP  = 8'b0001_0010,
    MTLO_OP  = 8'b0001_0011,
    LW_OP    = 8'b1110_0011
  } alu_op_e;

  // Result class encodings
  typedef enum logic [2:0] {
    RES_NOP        = 3'b000,
    RES_LOGIC      = 3'b001,
    RES_SHIFT      = 3'b010,
    RES_MOVE       = 3'b011,
    RES_ARITH      = 3'b100,
    RES_LOAD_STORE = 3'b111
  } alu_sel_e;

  // Everything the decoder extracts from one instruction word
  typedef struct packed {
    logic        r1_read;
    logic        r2_read;
    logic [31:0] imm;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  dest;
    logic        wreg;
    logic        is_load;
    logic        valid;
    logic        movz;
    logic        movn;
  } decode_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if
// Bundle of every decode-stage signal except clock and reset.
//   master : IF/ID side, regfile and forwarding network (drives *_in)
//   slave  : the decode stage itself (drives *_out)
interface id_stage_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  logic                       stall_in;
  logic                       flush_in;
  logic [31:0]                pc_in;
  logic [31:0]                inst_in;
  logic [DATA_W-1:0]          rs_data_in;
  logic [DATA_W-1:0]          rt_data_in;
  logic [NUM_FWD-1:0]         fwd_wreg_in;
  logic [NUM_FWD*RADDR_W-1:0] fwd_addr_in;
  logic [NUM_FWD*DATA_W-1:0]  fwd_data_in;
  logic                       ex_is_load_in;

  logic                       rs_read_out;
  logic                       rt_read_out;
  logic [RADDR_W-1:0]         rs_addr_out;
  logic [RADDR_W-1:0]         rt_addr_out;
  logic                       stall_req_out;
  logic [31:0]                ex_pc_out;
  logic [ALUOP_W-1:0]         ex_aluop_out;
  logic [ALUSEL_W-1:0]        ex_alusel_out;
  logic [DATA_W-1:0]          ex_src1_out;
  logic [DATA_W-1:0]          ex_src2_out;
  logic [RADDR_W-1:0]         ex_dest_addr_out;
  logic                       ex_wreg_out;
  logic                       ex_is_load_out;
  logic                       ex_inst_valid_out;

  modport master (
    output stall_in, flush_in, pc_in, inst_in, rs_data_in, rt_data_in,
           fwd_wreg_in, fwd_addr_in, fwd_data_in, ex_is_load_in,
    input  rs_read_out, rt_read_out, rs_addr_out, rt_addr_out, stall_req_out,
           ex_pc_out, ex_aluop_out, ex_alusel_out, ex_src1_out, ex_src2_out,
           ex_dest_addr_out, ex_wreg_out, ex_is_load_out, ex_inst_valid_out
  );

  modport slave (
    input  stall_in, flush_in, pc_in, inst_in, rs_data_in, rt_data_in,
           fwd_wreg_in, fwd_addr_in, fwd_data_in, ex_is_load_in,
    output rs_read_out, rt_read_out, rs_addr_out, rt_addr_out, stall_req_out,
           ex_pc_out, ex_aluop_out, ex_alusel_out, ex_src1_out, ex_src2_out,
           ex_dest_addr_out, ex_wreg_out, ex_is_load_out, ex_inst_valid_out
  );
endinterface

// File: rtl/id_stage_pipe_fwd_mux.sv
// fwd_mux
// Resolves one source operand of the decode stage.
//   read_en   : operand comes from a register (1) or the immediate (0)
//   addr      : register number being read
//   reg_data  : register file value for addr
//   imm       : decoded immediate
//   fwd_*     : packed forwarding sources, index 0 youngest
//   operand   : resolved value
module fwd_mux #(
  parameter int NUM_FWD = 2,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                       read_en,
  input  logic [RADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic [DATA_W-1:0]          imm,
  input  logic [NUM_FWD-1:0]         fwd_wreg,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  output logic [DATA_W-1:0]          operand
);

  // $0 is hard-wired zero no matter what is in flight. The scan runs from
  // the oldest source down so that the youngest matching source is the
  // last one written and therefore wins.
  always_comb begin
    operand = reg_data;
    if (!read_en) begin
      operand = imm;
    end else if (addr == '0) begin
      operand = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_wreg[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == addr)) begin
          operand = fwd_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// MIPS32 decode stage: decodes the instruction in ID, drives register file
// read ports, resolves operands through the forwarding network, raises a
// load-use stall request and registers the result into the ID/EX register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : id_stage_pipe_if slave port carrying all data/control
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input logic           clk,
  input logic           rst,
  id_stage_pipe_if.slave bus
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;

  assign op    = bus.inst_in[31:26];
  assign rs    = bus.inst_in[25:21];
  assign rt    = bus.inst_in[20:16];
  assign rd    = bus.inst_in[15:11];
  assign shamt = bus.inst_in[10:6];
  assign funct = bus.inst_in[5:0];
  assign imm16 = bus.inst_in[15:0];

  decode_t dec;

  // Register-form SPECIAL instructions require a zero shamt field; the
  // immediate-shift forms are only recognised with rs and the upper opcode
  // bits all zero. Anything unmatched stays a bubble-like NOP.
  always_comb begin
    dec = '0;
    if (op == OP_SPECIAL && shamt == 5'd0) begin
      case (funct)
        F_AND, F_OR, F_XOR, F_NOR: begin
          dec.r1_read = 1'b1;
          dec.r2_read = 1'b1;
          dec.dest    = rd;
          dec.wreg    = 1'b1;
          dec.valid   = 1'b1;
          dec.alusel  = RES_LOGIC;
          dec.aluop   = (funct == F_AND) ? AND_OP :
                        (funct == F_OR)  ? OR_OP  :
                        (funct == F_XOR) ? XOR_OP : NOR_OP;
        end
        F_SLLV, F_SRLV, F_SRAV: begin
          dec.r1_read = 1'b1;
          dec.r2_read = 1'b1;
          dec.dest    = rd;
          dec.wreg    = 1'b1;
          dec.valid   = 1'b1;
          dec.alusel  = RES_SHIFT;
          dec.aluop   = (funct == F_SLLV) ? SLL_OP :
                        (funct == F_SRLV) ? SRL_OP : SRA_OP;
        end
        F_ADDU: begin
          dec.r1_read = 1'b1;
          dec.r2_read = 1'b1;
          dec.dest    = rd;
          dec.wreg    = 1'b1;
          dec.valid   = 1'b1;
          dec.alusel  = RES_ARITH;
          dec.aluop   = ADDU_OP;
        end
        F_MOVZ, F_MOVN: begin
          dec.r1_read = 1'b1;
          dec.r2_read = 1'b1;
          dec.dest    = rd;
          dec.valid   = 1'b1;
          dec.alusel  = RES_MOVE;
          dec.movz    = (funct == F_MOVZ);
          dec.movn    = (funct == F_MOVN);
          dec.aluop   = (funct == F_MOVZ) ? MOVZ_OP : MOVN_OP;
        end
        F_MFHI, F_MFLO: begin
          dec.dest   = rd;
          dec.wreg   = 1'b1;
          dec.valid  = 1'b1;
          dec.alusel = RES_MOVE;
          dec.aluop  = (funct == F_MFHI) ? MFHI_OP : MFLO_OP;
        end
        F_MTHI, F_MTLO: begin
          dec.r1_read = 1'b1;
          dec.dest    = rd;
          dec.valid   = 1'b1;
          dec.aluop   = (funct == F_MTHI) ? MTHI_OP : MTLO_OP;
        end
        F_SYNC: begin
          dec.r2_read = 1'b1;
          dec.dest    = rd;
          dec.valid   = 1'b1;
        end
        default: ;
      endcase
    end
    if (bus.inst_in[31:21] == 11'd0 &&
        (funct == F_SLL || funct == F_SRL || funct == F_SRA)) begin
      dec.r1_read = 1'b0;
      dec.r2_read = 1'b1;
      dec.imm     = {27'd0, shamt};
      dec.dest    = rd;
      dec.wreg    = 1'b1;
      dec.valid   = 1'b1;
      dec.alusel  = RES_SHIFT;
      dec.aluop   = (funct == F_SLL) ? SLL_OP :
                    (funct == F_SRL) ? SRL_OP : SRA_OP;
    end
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.r1_read = 1'b1;
        dec.imm     = zero_ext16(imm16);
        dec.dest    = rt;
        dec.wreg    = 1'b1;
        dec.valid   = 1'b1;
        dec.alusel  = RES_LOGIC;
        dec.aluop   = (op == OP_ANDI) ? AND_OP :
                      (op == OP_ORI)  ? OR_OP  : XOR_OP;
      end
      OP_LUI: begin
        dec.r1_read = 1'b1;
        dec.imm     = {imm16, 16'h0000};
        dec.dest    = rt;
        dec.wreg    = 1'b1;
        dec.valid   = 1'b1;
        dec.alusel  = RES_LOGIC;
        dec.aluop   = OR_OP;
      end
      OP_ADDIU: begin
        dec.r1_read = 1'b1;
        dec.imm     = sign_ext16(imm16);
        dec.dest    = rt;
        dec.wreg    = 1'b1;
        dec.valid   = 1'b1;
        dec.alusel  = RES_ARITH;
        dec.aluop   = ADDIU_OP;
      end
      OP_LW: begin
        dec.r1_read = 1'b1;
        dec.imm     = sign_ext16(imm16);
        dec.dest    = rt;
        dec.wreg    = 1'b1;
        dec.is_load = 1'b1;
        dec.valid   = 1'b1;
        dec.alusel  = RES_LOAD_STORE;
        dec.aluop   = LW_OP;
      end
      OP_PREF: begin
        dec.dest  = rt;
        dec.valid = 1'b1;
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] imm_w;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;

  assign imm_w           = DATA_W'(dec.imm);
  assign bus.rs_read_out = dec.r1_read;
  assign bus.rt_read_out = dec.r2_read;
  assign bus.rs_addr_out = RADDR_W'(rs);
  assign bus.rt_addr_out = RADDR_W'(rt);

  fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rs_mux (
    .read_en  (dec.r1_read),
    .addr     (bus.rs_addr_out),
    .reg_data (bus.rs_data_in),
    .imm      (imm_w),
    .fwd_wreg (bus.fwd_wreg_in),
    .fwd_addr (bus.fwd_addr_in),
    .fwd_data (bus.fwd_data_in),
    .operand  (src1)
  );

  fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rt_mux (
    .read_en  (dec.r2_read),
    .addr     (bus.rt_addr_out),
    .reg_data (bus.rt_data_in),
    .imm      (imm_w),
    .fwd_wreg (bus.fwd_wreg_in),
    .fwd_addr (bus.fwd_addr_in),
    .fwd_data (bus.fwd_data_in),
    .operand  (src2)
  );

  // Conditional moves decide their write enable from the forwarded rt value,
  // so a just-produced zero/non-zero is seen without waiting for writeback.
  logic wreg_final;
  always_comb begin
    wreg_final = dec.wreg;
    if (dec.movz) begin
      wreg_final = (src2 == '0);
    end else if (dec.movn) begin
      wreg_final = (src2 != '0);
    end
  end

  // A load in EX cannot forward its data in time; any read of its
  // destination (other than $0) must wait one cycle.
  logic [RADDR_W-1:0] ex_dest;
  logic               load_hit;
  assign ex_dest  = bus.fwd_addr_in[RADDR_W-1:0];
  assign load_hit = (dec.r1_read && ex_dest == bus.rs_addr_out) ||
                    (dec.r2_read && ex_dest == bus.rt_addr_out);
  assign bus.stall_req_out = (rst != RstEnable) && bus.ex_is_load_in &&
                             bus.fwd_wreg_in[0] && (ex_dest != '0) && load_hit;

  // ID/EX register: reset and flush beat a downstream hold, a downstream
  // hold beats our own stall request, and a stall request inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || bus.flush_in || (!bus.stall_in && bus.stall_req_out)) begin
      bus.ex_pc_out         <= ZeroWord;
      bus.ex_aluop_out      <= ALUOP_W'(NOP_OP);
      bus.ex_alusel_out     <= ALUSEL_W'(RES_NOP);
      bus.ex_src1_out       <= '0;
      bus.ex_src2_out       <= '0;
      bus.ex_dest_addr_out  <= '0;
      bus.ex_wreg_out       <= 1'b0;
      bus.ex_is_load_out    <= 1'b0;
      bus.ex_inst_valid_out <= 1'b0;
    end else if (!bus.stall_in) begin
      bus.ex_pc_out         <= bus.pc_in;
      bus.ex_aluop_out      <= ALUOP_W'(dec.aluop);
      bus.ex_alusel_out     <= ALUSEL_W'(dec.alusel);
      bus.ex_src1_out       <= src1;
      bus.ex_src2_out       <= src2;
      bus.ex_dest_addr_out  <= RADDR_W'(dec.dest);
      bus.ex_wreg_out       <= wreg_final;
      bus.ex_is_load_out    <= dec.is_load;
      bus.ex_inst_valid_out <= dec.valid;
    end
  end

endmodule
